// File: rtl/q_log_pkg.sv
// Shared record layout for the Q change logger: {Q, TS, DROP} packed MSB to LSB.
// Widths are fixed by the instantiating module, so offsets are derived through functions.
package q_log_pkg;
   localparam int REC_MAX_W = 128;
   typedef logic [REC_MAX_W-1:0] rec_bus_t;

   localparam int DROP_OFF = 0;
   localparam int DROP_W   = 1;
   localparam int TS_OFF   = DROP_OFF + DROP_W;

   function automatic int q_off(input int ts_w);
      return TS_OFF + ts_w;
   endfunction

   function automatic int rec_w(input int w, input int ts_w);
      return w + ts_w + DROP_W;
   endfunction

   // Callers truncate the result to rec_w(); the upper bits are always zero.
   function automatic rec_bus_t pack_rec(input rec_bus_t q, input rec_bus_t ts,
                                         input logic drop, input int ts_w);
      return (q << q_off(ts_w)) | (ts << TS_OFF) | rec_bus_t'(drop);
   endfunction
endpackage

// File: rtl/q_log_fifo.sv
// Show-ahead synchronous FIFO; extra pointer MSB separates full from empty.
module q_log_fifo
   import q_log_pkg::*;
#(
   parameter  int DW    = 41,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          C,
   input  logic          R,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic [DW-1:0] dout,
   output logic [AW:0]   level,
   output logic          full,
   output logic          empty
);
   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
   logic          push_ok, pop_ok;

   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign level = wr_q - rd_q;
   assign dout  = mem_q[rd_q[AW-1:0]];

   assign pop_ok  = pop & ~empty;
   // When full, a same-cycle pop frees the slot that the push overwrites.
   assign push_ok = push & (~full | pop_ok);

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      if (push_ok) begin
         mem_d[wr_q[AW-1:0]] = din;
         wr_d = wr_q + 1'b1;
      end
      if (pop_ok) rd_d = rd_q + 1'b1;
   end

   always_ff @(posedge C) begin
      if (R) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
      end
   end
endmodule

// File: rtl/q_change_logger.sv
// Samples a flop bank's Q vector every cycle and logs each change as a
// timestamped record, flagging a power-up mismatch against INIT.
module q_change_logger
   import q_log_pkg::*;
#(
   parameter  int               WIDTH = 24,
   parameter  int               DEPTH = 8,
   parameter  int               TS_W  = 16,
   parameter  logic [WIDTH-1:0] INIT  = '0,
   localparam int               LW    = $clog2(DEPTH) + 1
) (
   input  logic             C,
   input  logic             R,
   input  logic [WIDTH-1:0] Q_IN,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] OUT_Q,
   output logic [TS_W-1:0]  OUT_TS,
   output logic             OUT_DROP,
   output logic             INIT_ERR,
   output logic [LW-1:0]    LEVEL
);
   localparam int REC_W = rec_w(WIDTH, TS_W);
   localparam int Q_OFF = q_off(TS_W);

   logic [WIDTH-1:0] prev_q, prev_d;
   logic [TS_W-1:0]  ts_q, ts_d;
   logic             first_q, first_d;
   logic             drop_pend_q, drop_pend_d;
   logic             init_err_q, init_err_d;

   logic             push_req, pop_req, push_lost, full, empty;
   logic [REC_W-1:0] din, dout;

   assign push_req  = (Q_IN != prev_q);
   assign pop_req   = OUT_VALID & OUT_READY;
   assign push_lost = push_req & full & ~pop_req;
   assign din       = REC_W'(pack_rec(rec_bus_t'(Q_IN), rec_bus_t'(ts_q), drop_pend_q, TS_W));

   always_comb begin
      prev_d      = Q_IN;
      ts_d        = ts_q + 1'b1;
      first_d     = 1'b0;
      init_err_d  = init_err_q | (first_q & (Q_IN != INIT));
      drop_pend_d = drop_pend_q;
      if (push_lost)     drop_pend_d = 1'b1;
      else if (push_req) drop_pend_d = 1'b0;
   end

   always_ff @(posedge C) begin
      if (R) begin
         prev_q      <= INIT;
         ts_q        <= '0;
         first_q     <= 1'b1;
         drop_pend_q <= 1'b0;
         init_err_q  <= 1'b0;
      end else begin
         prev_q      <= prev_d;
         ts_q        <= ts_d;
         first_q     <= first_d;
         drop_pend_q <= drop_pend_d;
         init_err_q  <= init_err_d;
      end
   end

   q_log_fifo #(.DW(REC_W), .DEPTH(DEPTH)) u_fifo (
      .C     (C),
      .R     (R),
      .push  (push_req),
      .din   (din),
      .pop   (pop_req),
      .dout  (dout),
      .level (LEVEL),
      .full  (full),
      .empty (empty)
   );

   assign OUT_VALID = ~empty;
   assign OUT_Q     = dout[Q_OFF +: WIDTH];
   assign OUT_TS    = dout[TS_OFF +: TS_W];
   assign OUT_DROP  = dout[DROP_OFF];
   assign INIT_ERR  = init_err_q;
endmodule
